// File: rtl/seg_scan_pkg.sv
// Shared constants and width helpers for the seven-segment scanner.
package seg_scan_pkg;

  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_DARK = 7'b0;

  // Width of the digit index; never narrower than one bit.
  function automatic int idx_width(input int num_digits);
    int w;
    if (num_digits <= 1) begin
      w = 1;
    end else begin
      w = $clog2(num_digits);
    end
    return w;
  endfunction

  // Width of a counter that runs 0..div-1; never narrower than one bit.
  function automatic int cnt_width(input int div);
    int w;
    if (div <= 1) begin
      w = 1;
    end else begin
      w = $clog2(div);
    end
    return w;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot prescaler and digit index for the scanner; flags describe the
// current (cnt, idx) state so the top can register its outputs from them.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 1000,
  parameter int GUARD      = 2,
  localparam int IW        = idx_width(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] idx_o,
  output logic          boundary_o,
  output logic          guard_o,
  output logic          frame_start_o
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_end_s;
  logic          last_digit_s;

  assign slot_end_s    = (cnt_q == CNT_MAX);
  assign last_digit_s  = (idx_q == IDX_MAX);
  assign boundary_o    = slot_end_s & last_digit_s;
  assign frame_start_o = (cnt_q == {CW{1'b0}}) & (idx_q == {IW{1'b0}});
  assign idx_o         = idx_q;

  // Dark interval at the head of each slot; absent entirely when GUARD is 0.
  if (GUARD == 0) begin : g_no_guard
    assign guard_o = 1'b0;
  end else begin : g_guard
    assign guard_o = (cnt_q < CW'(GUARD));
  end

  // Next prescaler count and digit index, wrapping at slot and frame ends.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_end_s) begin
      cnt_d = {CW{1'b0}};
      if (last_digit_s) begin
        idx_d = {IW{1'b0}};
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Prescaler and index state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CW{1'b0}};
      idx_q <= {IW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment scanner with guard interval and frame-synchronous
// double buffering. Optional blinking is enabled with SEG_SCAN_BLINK_EN.
module seven_segment_scan
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 1000,
  parameter int GUARD      = 2
`ifdef SEG_SCAN_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]       blink_mask,
`endif
  input  logic                        load,
  output logic [SEG_W-1:0]            data_out,
  output logic [NUM_DIGITS-1:0]       data_pos,
  output logic                        pending,
  output logic                        frame_tick
);

  localparam int IW = idx_width(NUM_DIGITS);

  logic [IW-1:0] idx_s;
  logic          boundary_s;
  logic          guard_s;
  logic          frame_start_s;

  seg_scan_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .DIV       (DIV),
    .GUARD     (GUARD)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .idx_o        (idx_s),
    .boundary_o   (boundary_s),
    .guard_o      (guard_s),
    .frame_start_o(frame_start_s)
  );

  logic [NUM_DIGITS-1:0][SEG_W-1:0] act_seg_q, act_seg_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] pend_seg_q, pend_seg_d;
  logic [NUM_DIGITS-1:0]            act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]            pend_blank_q, pend_blank_d;
  logic                             pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0]            blank_eff_s;

  logic [SEG_W-1:0]      data_out_q, data_out_d;
  logic [NUM_DIGITS-1:0] data_pos_q, data_pos_d;
  logic                  frame_tick_q, frame_tick_d;

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = cnt_width(BLINK_FRAMES);
  localparam logic [BW-1:0] BF_MAX = BW'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0] act_blink_q, act_blink_d;
  logic [NUM_DIGITS-1:0] pend_blink_q, pend_blink_d;
  logic [BW-1:0]         bf_cnt_q, bf_cnt_d;
  logic                  phase_on_q, phase_on_d;

  assign blank_eff_s = act_blank_q | (act_blink_q & {NUM_DIGITS{~phase_on_q}});

  // Frame counter toggling the blink phase every BLINK_FRAMES frames.
  always_comb begin
    bf_cnt_d   = bf_cnt_q;
    phase_on_d = phase_on_q;
    if (boundary_s) begin
      if (bf_cnt_q == BF_MAX) begin
        bf_cnt_d   = {BW{1'b0}};
        phase_on_d = ~phase_on_q;
      end else begin
        bf_cnt_d   = bf_cnt_q + BW'(1);
      end
    end else begin
      bf_cnt_d = bf_cnt_q;
    end
  end

  // Blink counter and phase state; phase starts on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bf_cnt_q   <= {BW{1'b0}};
      phase_on_q <= 1'b1;
    end else begin
      bf_cnt_q   <= bf_cnt_d;
      phase_on_q <= phase_on_d;
    end
  end
`else
  assign blank_eff_s = act_blank_q;
`endif

  // Buffer swap: a boundary load goes straight to active, otherwise pending
  // data is promoted; loads elsewhere only update the pending buffer.
  always_comb begin
    act_seg_d    = act_seg_q;
    act_blank_d  = act_blank_q;
    pend_seg_d   = pend_seg_q;
    pend_blank_d = pend_blank_q;
    pend_flag_d  = pend_flag_q;
`ifdef SEG_SCAN_BLINK_EN
    act_blink_d  = act_blink_q;
    pend_blink_d = pend_blink_q;
`endif
    if (boundary_s) begin
      pend_flag_d = 1'b0;
      if (load) begin
        act_seg_d   = seg_in;
        act_blank_d = blank_mask;
`ifdef SEG_SCAN_BLINK_EN
        act_blink_d = blink_mask;
`endif
      end else if (pend_flag_q) begin
        act_seg_d   = pend_seg_q;
        act_blank_d = pend_blank_q;
`ifdef SEG_SCAN_BLINK_EN
        act_blink_d = pend_blink_q;
`endif
      end else begin
        act_seg_d   = act_seg_q;
        act_blank_d = act_blank_q;
      end
    end else begin
      if (load) begin
        pend_seg_d   = seg_in;
        pend_blank_d = blank_mask;
        pend_flag_d  = 1'b1;
`ifdef SEG_SCAN_BLINK_EN
        pend_blink_d = blink_mask;
`endif
      end else begin
        pend_flag_d = pend_flag_q;
      end
    end
  end

  // Output decode for the current slot position.
  always_comb begin
    data_pos_d   = {NUM_DIGITS{1'b0}};
    data_out_d   = SEG_DARK;
    frame_tick_d = frame_start_s;
    if (!guard_s) begin
      data_pos_d = NUM_DIGITS'(1) << idx_s;
      if (blank_eff_s[idx_s]) begin
        data_out_d = SEG_DARK;
      end else begin
        data_out_d = act_seg_q[idx_s];
      end
    end else begin
      data_pos_d = {NUM_DIGITS{1'b0}};
      data_out_d = SEG_DARK;
    end
  end

  // Buffer, flag and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_seg_q    <= {(SEG_W*NUM_DIGITS){1'b0}};
      act_blank_q  <= {NUM_DIGITS{1'b0}};
      pend_seg_q   <= {(SEG_W*NUM_DIGITS){1'b0}};
      pend_blank_q <= {NUM_DIGITS{1'b0}};
      pend_flag_q  <= 1'b0;
`ifdef SEG_SCAN_BLINK_EN
      act_blink_q  <= {NUM_DIGITS{1'b0}};
      pend_blink_q <= {NUM_DIGITS{1'b0}};
`endif
      data_out_q   <= SEG_DARK;
      data_pos_q   <= {NUM_DIGITS{1'b0}};
      frame_tick_q <= 1'b0;
    end else begin
      act_seg_q    <= act_seg_d;
      act_blank_q  <= act_blank_d;
      pend_seg_q   <= pend_seg_d;
      pend_blank_q <= pend_blank_d;
      pend_flag_q  <= pend_flag_d;
`ifdef SEG_SCAN_BLINK_EN
      act_blink_q  <= act_blink_d;
      pend_blink_q <= pend_blink_d;
`endif
      data_out_q   <= data_out_d;
      data_pos_q   <= data_pos_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_pos   = data_pos_q;
  assign pending    = pend_flag_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench for seven_segment_scan with NUM_DIGITS=4, DIV=4, GUARD=1.
module tb_seven_segment_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] seg_in = 28'd0;
  logic [3:0]  blank_mask = 4'd0;
`ifdef SEG_SCAN_BLINK_EN
  logic [3:0]  blink_mask = 4'd0;
`endif
  logic        load = 1'b0;
  logic [6:0]  data_out;
  logic [3:0]  data_pos;
  logic        pending;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;
  int p;
  logic [6:0] exp_seg [4];
  logic       exp_pend;

  seven_segment_scan #(
    .NUM_DIGITS(4),
    .DIV       (4),
    .GUARD     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .blank_mask(blank_mask),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .load      (load),
    .data_out  (data_out),
    .data_pos  (data_pos),
    .pending   (pending),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at p=%0d: got=%h want=%h", tag, p, obs, exp);
    end
  endtask

  // Advance one cycle and compare outputs with the expected scan position.
  task automatic step_chk(input string tag);
    int c;
    int d;
    logic       e_ft;
    logic [3:0] e_pos;
    logic [6:0] e_out;
    @(negedge clk);
    p = p + 1;
    c = p % 4;
    d = (p / 4) % 4;
    e_ft = (p % 16 == 0);
    if (c == 0) begin
      e_pos = 4'd0;
      e_out = 7'd0;
    end else begin
      e_pos = 4'(1 << d);
      e_out = exp_seg[d];
    end
    check_eq(tag, {20'd0, frame_tick, data_pos, data_out}, {20'd0, e_ft, e_pos, e_out});
    check_eq({tag, "_pend"}, {31'd0, pending}, {31'd0, exp_pend});
  endtask

  task automatic run_to(input int target, input string tag);
    while (p < target) step_chk(tag);
  endtask

  initial begin
    p = -1;
    for (int i = 0; i < 4; i++) exp_seg[i] = 7'd0;
    exp_pend = 1'b0;

    // Reset held: everything dark.
    #2 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("reset", {19'd0, pending, frame_tick, data_pos, data_out}, 32'd0);
    end
    rst = 1'b1;

    // Idle scanning, two frames.
    run_to(31, "idle");

    // Mid-frame load, seen at phase 37.
    run_to(36, "pre_load");
    seg_in = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    load = 1'b1;
    exp_pend = 1'b1;
    step_chk("load");
    load = 1'b0;
    run_to(46, "wait_swap");
    exp_pend = 1'b0;
    step_chk("boundary1");
    exp_seg[0] = 7'h3F; exp_seg[1] = 7'h06; exp_seg[2] = 7'h5B; exp_seg[3] = 7'h4F;
    run_to(63, "shown");

    // Blank digit 2.
    run_to(65, "pre_blank");
    blank_mask = 4'b0100;
    load = 1'b1;
    exp_pend = 1'b1;
    step_chk("blank_load");
    load = 1'b0;
    run_to(78, "blank_wait");
    exp_pend = 1'b0;
    step_chk("boundary2");
    exp_seg[2] = 7'h00;
    run_to(95, "blanked");

    // Load exactly on the boundary cycle (phase 111).
    run_to(110, "pre_bload");
    seg_in = {7'h4F, 7'h5B, 7'h06, 7'h7F};
    blank_mask = 4'b0000;
    load = 1'b1;
    step_chk("bnd_load");
    load = 1'b0;
    exp_seg[0] = 7'h7F; exp_seg[2] = 7'h5B;
    run_to(127, "bnd_shown");

    // Back-to-back loads, last wins.
    run_to(129, "pre_b2b");
    seg_in = {7'h4F, 7'h5B, 7'h06, 7'h01};
    load = 1'b1;
    exp_pend = 1'b1;
    step_chk("b2b_first");
    seg_in = {7'h4F, 7'h5B, 7'h06, 7'h02};
    step_chk("b2b_second");
    load = 1'b0;
    run_to(142, "b2b_wait");
    exp_pend = 1'b0;
    step_chk("boundary4");
    exp_seg[0] = 7'h02;
    run_to(159, "b2b_shown");

    // Pending load then reset mid-slot of digit 2.
    run_to(167, "pre_rst");
    seg_in = {7'h4F, 7'h5B, 7'h06, 7'h11};
    load = 1'b1;
    exp_pend = 1'b1;
    step_chk("rst_pre_load");
    load = 1'b0;
    step_chk("rst_pre_d2");
    rst = 1'b0;
    #1;
    check_eq("rst_async", {19'd0, pending, frame_tick, data_pos, data_out}, 32'd0);
    @(negedge clk);
    check_eq("rst_hold", {19'd0, pending, frame_tick, data_pos, data_out}, 32'd0);
    rst = 1'b1;
    p = -1;
    for (int i = 0; i < 4; i++) exp_seg[i] = 7'd0;
    exp_pend = 1'b0;
    run_to(31, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Parametrised multiplexed seven-segment scanner, the successor to the two-digit `seven_segment` block. It drives NUM_DIGITS digits from a packed segment bus and uses a programmable slot period. Each slot starts with an anti-ghosting guard interval. New data is double-buffered and swapped only at frame boundaries, so the display never shows a partially updated frame. It sits between the per-digit `display` decoders and the board segment/position pins.

## Interface
- NUM_DIGITS, 8: digits scanned, legal 1..16.
- DIV, 1000: clk cycles per digit slot, legal ≥ GUARD+1.
- GUARD, 2: cycles at slot start with all outputs dark, legal 0..DIV-1.
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-low reset.
- seg_in  in  7*NUM_DIGITS: segment patterns. Digit k occupies [7k+6:7k]. Active-high, one bit per segment.
- blank_mask  in  NUM_DIGITS: bit k=1 blanks digit k. Captured together with seg_in.
- load  in  1: one-cycle strobe that captures seg_in and blank_mask.
- data_out  out  7: segments of the currently selected digit, active-high.
- data_pos  out  NUM_DIGITS: one-hot digit select, active-high.
- pending  out  1: captured data is waiting for the frame swap.
- frame_tick  out  1: one-cycle pulse when digit 0's slot begins.

## Operation
- Internal state:
  - prescaler cnt, 0..DIV-1.
  - digit index idx, 0..NUM_DIGITS-1.
  - pending buffer (seg, blank) and pending flag.
  - active buffer (seg, blank).
- cnt increments every cycle and wraps at DIV-1. On the wrap, idx increments; it wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the cycle where cnt==DIV-1 and idx==NUM_DIGITS-1.
  - On that cycle, active is loaded from seg_in/blank_mask if load=1.
  - Otherwise, if the pending flag is set, active is loaded from the pending buffer.
  - The pending flag clears in either case.
- load on any non-boundary cycle writes the pending buffer and sets the pending flag. Back-to-back loads: the last one wins.
- Output decode for the current (cnt, idx):
  - If cnt < GUARD: data_pos=0, data_out=0.
  - Otherwise: data_pos=1<<idx.
  - data_out = active.seg[idx], or 0 if the effective blank bit for idx is set.
- A blanked digit still occupies its slot. data_pos stays asserted, so brightness is uniform.
- frame_tick is set for the first cycle of digit 0's slot (cnt==0, idx==0).

## Timing
- All outputs are registered. An output at cycle t+1 reflects the state of cycle t, a fixed latency of 1 cycle.
- Reset (rst=0) clears cnt, idx, both buffers, the pending flag, data_out, data_pos and frame_tick, all asynchronously.
- The first rising edge after rst deasserts evaluates cnt=0, idx=0. The outputs registered at that edge carry frame_tick=1.
- Frame period is DIV*NUM_DIGITS cycles. frame_tick is exactly 1 cycle wide per frame.
- pending goes high 1 cycle after a non-boundary load. It goes low 1 cycle after the boundary cycle.
- New data appears on data_out starting in the slot of digit 0 that follows the swap.
- A rst assertion mid-slot or mid-frame drops all outputs immediately and discards pending data.
- With GUARD=0, there is no dark interval.
- With NUM_DIGITS=1, every slot end is a frame boundary.

## Configuration
- SEG_SCAN_BLINK_EN, when defined:
  - Adds parameter BLINK_FRAMES (default 64, ≥1).
  - Adds input blink_mask [NUM_DIGITS-1:0], captured with seg_in on load and swapped like blank_mask.
  - A frame counter toggles a blink phase every BLINK_FRAMES frames. The phase is on after reset.
  - During the off phase, digits with an active blink bit are blanked.
  - Effective blank = blank | (blink & off_phase).
- When not defined: no blink_mask port, no frame counter, and effective blank = blank.

## Structure
- Package seg_scan_pkg holds:
  - SEG_W=7.
  - SEG_DARK=7'b0.
  - A function giving the index width, max(1, clog2(NUM_DIGITS)).
  - A function giving the prescaler width from DIV.
- Sub-module seg_scan_timer contains cnt, idx, the boundary and guard flags, and frame_tick generation.
- The top level holds the buffers, the swap logic, the optional blink counter and the output registers.

## Test plan
All scenarios use NUM_DIGITS=4, DIV=4, GUARD=1.
- Reset release, idle: frame_tick is high 1 cycle every 16 cycles. data_pos cycles 0,1,1,1 / 0,2,2,2 / 0,4,4,4 / 0,8,8,8 (cycles per slot). data_out stays 0.
- Load seg_in with digits 7'h3F, 7'h06, 7'h5B, 7'h4F mid-frame:
  - pending rises 1 cycle after the load.
  - data_out stays 0 until the next frame.
  - Then it shows 3F/06/5B/4F in the respective slots, and pending falls.
- blank_mask=4'b0100 with the same data: during digit 2's slot, data_pos=4 and data_out=0. The other digits are unchanged.
- Load on the exact boundary cycle with digit 0 = 7'h7F: digit 0's next slot shows 7F, and pending never rises.
- Two loads in consecutive cycles, 7'h01 then 7'h02 on digit 0: after the swap, only 02 is displayed.
- rst pulsed low mid-slot of digit 2: data_pos=0 and data_out=0 immediately. After release, the next frame starts at digit 0 with blank data. With SEG_SCAN_BLINK_EN and BLINK_FRAMES=1, a blinking digit is dark on alternate frames.
